// File: rtl/definitions.sv
// Shared types for the handshaked execute-stage ALU: opcodes, flag layout and FSM states.
package definitions;

  localparam int DATA_W     = 16;
  localparam int ALU_OP_AMT = 8;

  typedef logic [DATA_W-1:0] t_data;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } t_opcode;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } t_flags;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } t_alu_state;

endpackage

// File: rtl/mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles total.
module mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      prod   <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        prod   <= '0;
        cnt    <= '0;
        busy   <= 1'b1;
      end else if (busy) begin
        // done is raised together with the final accumulation, so prod is complete when done=1
        if (mplier[0]) prod <= prod + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops go straight to the output register, MUL runs on mul_iter.
module alu_seq
  import definitions::*;
#(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  t_opcode          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output t_flags           flags
);

  localparam int SH_W = $clog2(WIDTH);

  t_alu_state         state;
  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [SH_W-1:0]    sh;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH:0]     shl_w;
  logic [WIDTH:0]     shr_w;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;

  function automatic t_flags mk_flags(logic [WIDTH-1:0] r, logic c, logic v);
    return '{z: (r == '0), n: r[WIDTH-1], c: c, v: v};
  endfunction

  // The extra bit of each shift vector catches the last bit shifted out (0 when sh==0)
  assign sh    = b[SH_W-1:0];
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shl_w = {1'b0, a} << sh;
  assign shr_w = {a, 1'b0} >> sh;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: begin
        alu_res = shl_w[WIDTH-1:0];
        alu_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_w[WIDTH:1];
        alu_c   = shr_w[0];
      end
      default: ;
    endcase
  end

  assign in_ready  = ((state == IDLE) && !mul_busy) || ((state == HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL) && MUL_EN;

  generate
    if (MUL_EN) begin : g_mul
      mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (a),
        .b     (b),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_prod)
      );
    end else begin : g_no_mul
      assign mul_busy = 1'b0;
      assign mul_done = 1'b0;
      assign mul_prod = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            if (mul_start) begin
              state     <= MUL;
              out_valid <= 1'b0;
            end else begin
              state     <= HOLD;
              out_valid <= 1'b1;
              result    <= alu_res;
              flags     <= mk_flags(alu_res, alu_c, alu_v);
            end
          end else if ((state == HOLD) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        MUL: begin
          if (mul_done) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            result    <= mul_prod[WIDTH-1:0];
            flags     <= mk_flags(mul_prod[WIDTH-1:0], |mul_prod[2*WIDTH-1:WIDTH],
                                  |mul_prod[2*WIDTH-1:WIDTH]);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=16 with the iterative multiplier enabled.
module tb_alu_seq;
  import definitions::*;

  localparam int W = 16;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  t_opcode      op        = OP_ADD;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  t_flags       flags;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Single-cycle op: result must be valid right after the accept edge
  task automatic do_op(input string tag, input t_opcode o, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [W-1:0] exp_r, input logic [3:0] exp_f);
    op = o; a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; a = ~av; b = ~bv; op = OP_SUB;
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".result"}, 32'(result), 32'(exp_r));
    chk({tag, ".flags"}, 32'(flags), 32'(exp_f));
    $display("[TB] %s a=%h b=%h -> result=%h flags=%b", tag, av, bv, result, flags);
    step();
    chk({tag, ".idle"}, 32'(out_valid), 32'd0);
  endtask

  task automatic do_mul(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] exp_r, input logic [3:0] exp_f);
    int bad;
    op = OP_MUL; a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; a = ~av; b = ~bv; op = OP_ADD;
    bad = 0;
    for (int i = 0; i < 17; i++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
      step();
    end
    chk({tag, ".busy"}, 32'(bad), 32'd0);
    chk({tag, ".valid17"}, 32'(out_valid), 32'd1);
    chk({tag, ".result"}, 32'(result), 32'(exp_r));
    chk({tag, ".flags"}, 32'(flags), 32'(exp_f));
    $display("[TB] %s a=%h b=%h -> result=%h flags=%b", tag, av, bv, result, flags);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;

    repeat (2) step();
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.result", 32'(result), 32'd0);
    chk("rst.flags", 32'(flags), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    do_op("add16_15", OP_ADD, 16'd16, 16'd15, 16'd31, 4'b0000);
    do_op("sub15_16", OP_SUB, 16'd15, 16'd16, 16'hFFFF, 4'b0110);
    do_op("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
    do_op("add_carry", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010);
    do_op("sub_ovf", OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001);
    do_op("and", OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000);
    do_op("or_zero", OP_OR, 16'h0000, 16'h0000, 16'h0000, 4'b1000);
    do_op("xor", OP_XOR, 16'hAAAA, 16'h5555, 16'hFFFF, 4'b0100);
    do_op("shl1", OP_SHL, 16'h8001, 16'h0011, 16'h0002, 4'b0010);
    do_op("shl0", OP_SHL, 16'h0003, 16'h00F0, 16'h0003, 4'b0000);
    do_op("shr0", OP_SHR, 16'h0001, 16'h0000, 16'h0001, 4'b0000);
    do_op("shr15", OP_SHR, 16'h8000, 16'h000F, 16'h0001, 4'b0000);
    do_op("shr1c", OP_SHR, 16'h0003, 16'h0001, 16'h0001, 4'b0010);

    do_mul("mul300", 16'd300, 16'd300, 16'h5F90, 4'b0011);
    do_mul("mul_ff", 16'h00FF, 16'h0101, 16'hFFFF, 4'b0100);

    // Backpressure: a competing request must not be taken while the result is held
    op = OP_ADD; a = 16'd5; b = 16'd6; in_valid = 1'b1; out_ready = 1'b0;
    step();
    op = OP_XOR; a = 16'h1234; b = 16'h4321;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 16'd11 || flags !== 4'b0000) bad++;
      step();
    end
    chk("bp.stable", 32'(bad), 32'd0);
    chk("bp.result", 32'(result), 32'd11);
    $display("[TB] backpressure held result=%h for 5 cycles", result);

    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op = OP_ADD; a = 16'(i * 3); b = 16'd100; in_valid = 1'b1;
      step();
      chk("stream.valid", 32'(out_valid), 32'd1);
      chk("stream.result", 32'(result), 32'(i * 3 + 100));
      $display("[TB] stream %0d a=%h b=%h -> result=%h", i, a, b, result);
    end
    in_valid = 1'b0;
    step();
    chk("stream.idle", 32'(out_valid), 32'd0);

    // Reset in the middle of a multiply
    op = OP_MUL; a = 16'd300; b = 16'd300; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.result", 32'(result), 32'd0);
    chk("midrst.flags", 32'(flags), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    $display("[TB] reset asserted mid-multiply, outputs cleared");
    do_op("post_rst_add", OP_ADD, 16'd1, 16'd1, 16'd2, 4'b0000);

    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid !== 1'b0) bad++;
      step();
    end
    chk("midrst.no_stale_mul", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
